sar_adc_controller: RTL and testbench
=====================================

Name: sar_adc_controller

Overview:
- Digital successive-approximation controller for a BITS-wide SAR ADC.
- On a single-cycle start pulse, it drives a trial code (adc_val) to the external capacitive DAC.
- Each cycle it reads the external comparator and resolves one bit, MSB first.
- It then holds the final code with out_valid high until reset or the next start.
- It sits between the edge-accelerator sequencer (start/valid) and the analog DAC/comparator front end.

Parameters:
- BITS, 8, conversion resolution; width of adc_val and of the bit counter logic.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- adc_start  input  1  start request, sampled on the rising edge; a one-cycle pulse is sufficient.
- comparator_val  input  1  comparator result. 1 means the DAC trial code is <= the input (keep the bit); 0 means the trial is too high (clear the bit). Must be stable at the rising edge; the analog side may update it on the falling edge.
- run_adc_n  output  1  active-low conversion enable / hold. 1 means idle or tracking the input; 0 means the input is held and the conversion is running or the result is held.
- adc_val  output  BITS  current trial code during conversion; final result once out_valid=1.
- out_valid  output  1  result valid flag.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, adc_val=0, out_valid=0, run_adc_n=1, bit index=BITS-1.
- The rising edge of run_adc_n at reset marks the start of input tracking.
- States: IDLE, CONVERT, DONE. All outputs are registered.
- IDLE:
  - run_adc_n=1, out_valid=0.
  - On adc_start=1: go to CONVERT, run_adc_n<=0, adc_val<=1 at MSB only (e.g. 0x80), idx<=BITS-1.
- CONVERT, each rising edge, with k=idx:
  - adc_val[k] <= comparator_val.
  - If k>0: adc_val[k-1]<=1 and idx<=k-1.
  - If k==0: state<=DONE and out_valid<=1.
  - Lower, unresolved bits are 0 at every step.
- Latency: the start edge plus BITS cycles. out_valid rises on the BITS-th edge after the edge that captured adc_start (8 cycles for BITS=8); the result is valid 9 clock edges after start.
- adc_start is ignored while in CONVERT.
- DONE:
  - adc_val holds the final code, out_valid=1, run_adc_n stays 0 (input remains held).
  - adc_start=1 restarts: out_valid<=0, adc_val<=MSB trial, state<=CONVERT, run_adc_n stays 0.
  - Return to IDLE/tracking occurs only via rst_n.
- Reset mid-conversion: immediate return to the reset values; no partial result is flagged valid.
- Boundaries:
  - Input 0 yields adc_val=0.
  - Input full-scale yields all ones.
  - The comparator condition is inclusive (<=), so equality keeps the bit.
- comparator_val is never sampled outside CONVERT.

Decomposition:
- Shared package sar_adc_pkg holds the state enum (IDLE, CONVERT, DONE) and the default BITS constant.
- No sub-module; a single FSM plus a BITS-wide shift/one-hot bit pointer is natural.
- The bit pointer is either a $clog2(BITS) counter or a one-hot mask register.

Test Plan:
- Behavioural comparator model: comparator_val = (adc_val <= sample), updated on the falling edge.
- Reset, then a one-cycle start with sample=0xA5:
  - Trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - out_valid=1 and adc_val=0xA5 by 9 edges after start; run_adc_n=0 throughout.
- Sample=0x00 -> adc_val=0x00 with out_valid=1. Sample=0xFF -> adc_val=0xFF with out_valid=1.
- Assert rst_n=0 on the 4th cycle of a conversion: immediate adc_val=0, out_valid=0, run_adc_n=1. A new start then converts 0x3C correctly.
- Pulse adc_start again on the 3rd cycle of a conversion: ignored, result still correct and on time. Pulse adc_start in DONE: out_valid drops and a new conversion completes with the same held value.
- 50 iterations of reset, random sample, start, and a check 10 cycles later: out_valid===1 and adc_val===sample on every iteration.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_adc_pkg;

    // Default conversion resolution.
    localparam int DEFAULT_BITS = 8;

    // Controller states: tracking, resolving bits, holding the result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_adc_controller.sv
// Successive-approximation controller: drives trial codes to an external
// capacitive DAC, resolves one bit per cycle MSB first from the comparator,
// then holds the final code with out_valid high until reset or a restart.
module sar_adc_controller
    import sar_adc_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adc_start,
    input  logic            comparator_val,
    output logic            run_adc_n,
    output logic [BITS-1:0] adc_val,
    output logic            out_valid
);

    localparam int              IDX_W     = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(BITS - 1);
    localparam logic [BITS-1:0] MSB_TRIAL = BITS'(1) << (BITS - 1);

    sar_state_t       state_q, state_d;
    logic [BITS-1:0]  val_q, val_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             run_n_q, run_n_d;

    // Next-state and next-output logic for the conversion FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        run_n_d = run_n_q;

        unique case (state_q)
            IDLE: begin
                run_n_d = 1'b1;
                valid_d = 1'b0;
                if (adc_start) begin
                    state_d = CONVERT;
                    run_n_d = 1'b0;
                    val_d   = MSB_TRIAL;
                    idx_d   = IDX_MSB;
                end
            end

            CONVERT: begin
                // Keep the bit under trial when the trial code is <= input;
                // adc_start is deliberately ignored here.
                val_d[idx_q] = comparator_val;
                if (idx_q != '0) begin
                    val_d[idx_q - 1'b1] = 1'b1;
                    idx_d               = idx_q - 1'b1;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end

            DONE: begin
                // Input stays held; only a new start or reset leaves DONE.
                if (adc_start) begin
                    state_d = CONVERT;
                    valid_d = 1'b0;
                    val_d   = MSB_TRIAL;
                    idx_d   = IDX_MSB;
                end
            end

            default: begin
                state_d = IDLE;
                run_n_d = 1'b1;
                valid_d = 1'b0;
                val_d   = '0;
                idx_d   = IDX_MSB;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            idx_q   <= IDX_MSB;
            valid_q <= 1'b0;
            run_n_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            run_n_q <= run_n_d;
        end
    end

    assign adc_val   = val_q;
    assign out_valid = valid_q;
    assign run_adc_n = run_n_q;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Self-checking bench for sar_adc_controller: an ideal comparator model,
// a scoreboard of expected results/completion cycles, and a monitor that
// checks each out_valid rising edge against it.
module tb_sar_adc_controller;
    import sar_adc_pkg::*;

    localparam int BITS = DEFAULT_BITS;

    typedef struct {
        logic [BITS-1:0] value;
        int              due_cycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            adc_start = 1'b0;
    logic            comparator_val = 1'b0;
    logic            run_adc_n;
    logic [BITS-1:0] adc_val;
    logic            out_valid;

    logic [BITS-1:0] sample = '0;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    exp_t            sb[$];
    logic            valid_prev = 1'b0;

    sar_adc_controller #(.BITS(BITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_start      (adc_start),
        .comparator_val (comparator_val),
        .run_adc_n      (run_adc_n),
        .adc_val        (adc_val),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ideal analog front end: comparator settles on the falling edge.
    always @(negedge clk) comparator_val = (adc_val <= sample);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Binary-search trial code for step k: the top k bits of the sample
    // followed by a single 1, lower bits clear.
    function automatic logic [BITS-1:0] trial_code(input logic [BITS-1:0] s, input int k);
        int hi;
        hi = (int'(s) >> (BITS - k)) << (BITS - k);
        return BITS'(hi | (1 << (BITS - 1 - k)));
    endfunction

    // Monitor: every rising edge of out_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
        end else begin
            if (out_valid && !valid_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", adc_val, e.value);
                    check("latency", cyc, e.due_cycle);
                end
            end
            valid_prev = out_valid;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        adc_start = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue a start pulse and register the expected result; returns #1
    // after the edge that captured the start.
    task automatic start_conv(input logic [BITS-1:0] s);
        exp_t e;
        @(negedge clk);
        sample    = s;
        adc_start = 1'b1;
        @(posedge clk);
        #1;
        adc_start   = 1'b0;
        e.value     = s;
        e.due_cycle = cyc + BITS;
        sb.push_back(e);
    endtask

    task automatic pulse_start_only();
        @(negedge clk);
        adc_start = 1'b1;
        @(posedge clk);
        #1;
        adc_start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("pending_results", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BITS-1:0] s;

        // Reset values.
        do_reset();
        check("reset_adc_val", adc_val, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_run_adc_n", run_adc_n, 1);

        // 0xA5: full trial sequence, run_adc_n held low throughout.
        start_conv(8'hA5);
        for (int k = 0; k < BITS; k++) begin
            check($sformatf("trial_%0d", k), adc_val, trial_code(8'hA5, k));
            check($sformatf("run_n_%0d", k), run_adc_n, 0);
            check($sformatf("valid_low_%0d", k), out_valid, 0);
            @(posedge clk);
            #1;
        end
        check("a5_valid", out_valid, 1);
        check("a5_run_n", run_adc_n, 0);
        wait_done();

        // Boundaries: zero and full scale.
        start_conv(8'h00);
        wait_done();
        check("zero_valid", out_valid, 1);
        check("zero_val", adc_val, 8'h00);
        start_conv(8'hFF);
        wait_done();
        check("full_valid", out_valid, 1);
        check("full_val", adc_val, 8'hFF);

        // Reset in the middle of a conversion, then convert 0x3C.
        do_reset();
        start_conv(8'h77);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_adc_val", adc_val, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_run_adc_n", run_adc_n, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_conv(8'h3C);
        wait_done();
        check("after_rst_val", adc_val, 8'h3C);

        // Start during CONVERT is ignored; latency is checked by the monitor.
        do_reset();
        start_conv(8'h5A);
        @(posedge clk);
        pulse_start_only();
        wait_done();
        check("ignored_start_valid", out_valid, 1);

        // Restart from DONE: out_valid drops, then the same value reappears.
        start_conv(8'h5A);
        check("restart_valid_drop", out_valid, 0);
        check("restart_run_n", run_adc_n, 0);
        wait_done();
        check("restart_val", adc_val, 8'h5A);

        // Randomized conversions.
        for (int it = 0; it < 50; it++) begin
            do_reset();
            s = BITS'($urandom_range(0, (1 << BITS) - 1));
            start_conv(s);
            repeat (BITS + 1) @(posedge clk);
            #1;
            check($sformatf("rand_valid_%0d", it), out_valid, 1);
            check($sformatf("rand_val_%0d", it), adc_val, s);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
